// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight GPR writers in an E/M/W shadow pipeline with
// per-entry Tnew, compares them against decode Tuse to drive operand forward
// selects and the decode stall, and owns the HI/LO multiply/divide busy counter.
module hazard_ctrl #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid_i,
    input  logic [REG_W-1:0] d_rs_i,
    input  logic [REG_W-1:0] d_rt_i,
    input  logic [1:0]       d_tuse_rs_i,
    input  logic [1:0]       d_tuse_rt_i,
    input  logic             d_we_i,
    input  logic [REG_W-1:0] d_a3_i,
    input  logic [1:0]       d_tnew_i,
    input  logic             d_md_start_i,
    input  logic             d_md_div_i,
    input  logic             d_md_use_i,
    output logic             stall_o,
    output logic [1:0]       fwd_rs_d_o,
    output logic [1:0]       fwd_rt_d_o,
    output logic [1:0]       fwd_rs_e_o,
    output logic [1:0]       fwd_rt_e_o,
    output logic             fwd_rt_m_o,
    output logic             md_busy_o
);

    localparam logic [CNT_W-1:0] MulLat = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DivLat = CNT_W'(DIV_LAT);

    // E stage shadow
    logic             e_we_q, e_we_d;
    logic [REG_W-1:0] e_a3_q, e_a3_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [REG_W-1:0] e_rs_q, e_rs_d;
    logic [REG_W-1:0] e_rt_q, e_rt_d;
    logic             e_md_start_q, e_md_start_d;
    logic             e_md_div_q, e_md_div_d;
    // M stage shadow
    logic             m_we_q, m_we_d;
    logic [REG_W-1:0] m_a3_q, m_a3_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [REG_W-1:0] m_rt_q, m_rt_d;
    // W stage shadow; its Tnew is always 0 (max Tnew is 2), so it is not stored
    logic             w_we_q, w_we_d;
    logic [REG_W-1:0] w_a3_q, w_a3_d;
    // HI/LO busy counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic hit(input logic we, input logic [REG_W-1:0] a3,
                                 input logic [REG_W-1:0] r);
        return we && (a3 == r) && (r != '0);
    endfunction

    // A source must wait if a matching in-flight writer produces after it is consumed
    function automatic logic src_stall(input logic [REG_W-1:0] r, input logic [1:0] tuse,
                                       input logic ew, input logic [REG_W-1:0] ea,
                                       input logic [1:0] et, input logic mw,
                                       input logic [REG_W-1:0] ma, input logic [1:0] mt);
        return (tuse != 2'd3) &&
               ((hit(ew, ea, r) && (et > tuse)) || (hit(mw, ma, r) && (mt > tuse)));
    endfunction

    logic stall_rs, stall_rt, stall_md;

    // Stall decision and pipeline next-state
    always_comb begin
        stall_rs = src_stall(d_rs_i, d_tuse_rs_i, e_we_q, e_a3_q, e_tnew_q,
                             m_we_q, m_a3_q, m_tnew_q);
        stall_rt = src_stall(d_rt_i, d_tuse_rt_i, e_we_q, e_a3_q, e_tnew_q,
                             m_we_q, m_a3_q, m_tnew_q);
        stall_md = d_md_use_i && (e_md_start_q || md_busy_o);
        stall_o  = d_valid_i && (stall_rs || stall_rt || stall_md);

        // Stalled or empty D enters E as a bubble so its write is tracked once
        if (d_valid_i && !stall_o) begin
            e_we_d       = d_we_i;
            e_a3_d       = d_a3_i;
            e_tnew_d     = d_tnew_i;
            e_rs_d       = d_rs_i;
            e_rt_d       = d_rt_i;
            e_md_start_d = d_md_start_i;
            e_md_div_d   = d_md_div_i;
        end else begin
            e_we_d       = 1'b0;
            e_a3_d       = '0;
            e_tnew_d     = 2'd0;
            e_rs_d       = '0;
            e_rt_d       = '0;
            e_md_start_d = 1'b0;
            e_md_div_d   = 1'b0;
        end

        m_we_d   = e_we_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        m_rt_d   = e_rt_q;
        w_we_d   = m_we_q;
        w_a3_d   = m_a3_q;

        // A new mult/div leaving E reloads even if the unit is still busy
        if (e_md_start_q) begin
            cnt_d = e_md_div_q ? DivLat : MulLat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Shadow pipeline and busy counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_we_q       <= 1'b0;
            e_a3_q       <= '0;
            e_tnew_q     <= 2'd0;
            e_rs_q       <= '0;
            e_rt_q       <= '0;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            m_we_q       <= 1'b0;
            m_a3_q       <= '0;
            m_tnew_q     <= 2'd0;
            m_rt_q       <= '0;
            w_we_q       <= 1'b0;
            w_a3_q       <= '0;
            cnt_q        <= '0;
        end else begin
            e_we_q       <= e_we_d;
            e_a3_q       <= e_a3_d;
            e_tnew_q     <= e_tnew_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            m_we_q       <= m_we_d;
            m_a3_q       <= m_a3_d;
            m_tnew_q     <= m_tnew_d;
            m_rt_q       <= m_rt_d;
            w_we_q       <= w_we_d;
            w_a3_q       <= w_a3_d;
            cnt_q        <= cnt_d;
        end
    end

    // Newest ready producer wins; a not-yet-ready match falls through to older stages
    function automatic logic [1:0] sel_d(input logic [REG_W-1:0] r,
                                         input logic ew, input logic [REG_W-1:0] ea,
                                         input logic [1:0] et, input logic mw,
                                         input logic [REG_W-1:0] ma, input logic [1:0] mt,
                                         input logic ww, input logic [REG_W-1:0] wa);
        if (hit(ew, ea, r) && (et == 2'd0)) return 2'd3;
        if (hit(mw, ma, r) && (mt == 2'd0)) return 2'd1;
        if (hit(ww, wa, r))                 return 2'd2;
        return 2'd0;
    endfunction

    // Forward selects for D, E and M consumers
    always_comb begin
        md_busy_o  = (cnt_q != '0);
        fwd_rs_d_o = sel_d(d_rs_i, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q,
                           w_we_q, w_a3_q);
        fwd_rt_d_o = sel_d(d_rt_i, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q,
                           w_we_q, w_a3_q);
        // E consumers never see E as a source; the E shadow is disabled here
        fwd_rs_e_o = sel_d(e_rs_q, 1'b0, '0, 2'd0, m_we_q, m_a3_q, m_tnew_q,
                           w_we_q, w_a3_q);
        fwd_rt_e_o = sel_d(e_rt_q, 1'b0, '0, 2'd0, m_we_q, m_a3_q, m_tnew_q,
                           w_we_q, w_a3_q);
        fwd_rt_m_o = hit(w_we_q, w_a3_q, m_rt_q);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller: the successor to the combinational forwarding unit. It tracks in-flight register writers in its own E/M/W shadow pipeline with a per-entry Tnew countdown, and compares these against Tuse from decode. From that it produces forward selects for D/E/M operands, a decode stall and bubble insertion. It also owns a multiply/divide busy counter that stalls HI/LO consumers. It sits beside the decoder and is driven by decoded fields rather than raw instruction words.

## Interface
- REG_W, 5, register-address width
- MUL_LAT, 5, cycles HI/LO is busy after a multiply leaves E
- DIV_LAT, 10, cycles HI/LO is busy after a divide leaves E
- CNT_W, 4, busy-counter width; must hold max(MUL_LAT, DIV_LAT)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_valid  in  1  D holds a real instruction
- d_rs, d_rt  in  REG_W  source registers of D instruction
- d_tuse_rs, d_tuse_rt  in  2  cycles until operand is consumed: 0 = D, 1 = E, 2 = M, 3 = unused
- d_we  in  1  D instruction writes the GPR file
- d_a3  in  REG_W  destination register
- d_tnew  in  2  cycles from E entry until result exists: 0 = E (link), 1 = M (ALU), 2 = W (load)
- d_md_start, d_md_div  in  1  D is mult/div; 1 = divide
- d_md_use  in  1  D reads or writes HI/LO, or is mult/div
- stall  out  1  freeze PC and the D register; inject a bubble into E
- fwd_rs_d, fwd_rt_d  out  2  0 = GPR, 1 = M, 2 = W, 3 = E
- fwd_rs_e, fwd_rt_e  out  2  0 = pipe, 1 = M, 2 = W
- fwd_rt_m  out  1  1 = W
- md_busy  out  1  busy counter is nonzero

## Operation
- Shadow entries E, M, W each hold {we, a3, tnew}.
  - E additionally holds {rs, rt, md_start, md_div}.
  - M additionally holds {rt}.
- Each edge, W←M and M←E, with tnew decremented saturating at 0.
- E←D fields when !stall && d_valid. Otherwise E←bubble (all fields 0).
- An entry "matches" register r when we=1, a3==r and r!=0. Register 0 never matches, never forwards and never stalls.
- Data stall for a source r with tuse t: stall if E matches r with E.tnew>t, or M matches r with M.tnew>t. Sources with tuse=3 are ignored.
- Source selection, newest match first:
  - fwd_*_d: E match with tnew=0 gives 3; else M match with tnew=0 gives 1; else W match gives 2; else 0.
  - fwd_*_e: uses E.rs/E.rt. M match (tnew=0) gives 1; else W match gives 2; else 0.
  - fwd_rt_m: uses M.rt. W match gives 1.
- A match with tnew>0 never forwards. Selection then falls through to an older stage only if that stage matches with tnew=0. Otherwise the stall covers the case.
- MD stall: stall if d_md_use && (E.md_start || md_busy).
- stall is the OR of the rs data stall, the rt data stall and the MD stall. It is gated by d_valid.
- Busy counter:
  - If E.md_start, it loads DIV_LAT when E.md_div, else MUL_LAT.
  - Else, if it is nonzero, it decrements by 1.
  - The load has priority over the decrement.
- All outputs except md_busy are combinational from the D inputs and the registered state.

## Timing
- Reset (asynchronous, rst_n=0): all shadow entries become bubbles and the counter becomes 0.
  - stall, md_busy and all fwd_* are 0 during and after reset while d_valid=0.
  - Reset mid-multiply clears busy immediately.
- Load (tnew=2) followed by a dependent ALU op (tuse=1): 1 stall cycle. The value is then forwarded from W to E (fwd_*_e=2).
- ALU (tnew=1) followed by a branch consumer (tuse=0): 1 stall cycle. The value is then forwarded via fwd_*_d=1.
- Load followed by a branch consumer: 2 stall cycles.
- Mult in E at cycle t with mflo in D: stall during t. Counter is MUL_LAT at t+1, stall through t+MUL_LAT, release at t+MUL_LAT+1. That is MUL_LAT+1 stall cycles in total.
- During a stall, D inputs are held by the pipeline. The bubble ensures a stalled instruction's write is never tracked twice.
- A second mult entering E while busy reloads the counter.

## Test plan
- After reset, with d_valid=1, rs=rt=5 and no writers: stall=0 and all fwd=0. Pulse rst_n low while md_busy=1: md_busy drops to 0 asynchronously.
- Writer ALU a3=8 (tnew=1), next D rs=8 with tuse=1: stall=0. Next cycle fwd_rs_e=1. With tuse=0 instead: stall=1 for 1 cycle, then fwd_rs_d=1.
- Load a3=9, next D rt=9 with tuse=1: stall=1 exactly 1 cycle, then fwd_rt_e=2. With tuse=2 (store data): no stall, then fwd_rt_m=1.
- Writers a3=0 of every type: never any stall and all fwd=0. Two writers to r3 in E (tnew=0) and M: fwd_rs_d=3 (newest wins).
- mult (MUL_LAT=5) followed by mflo: stall for 6 cycles, md_busy high for 5. div (DIV_LAT=10): stall for 11 cycles.
- jal (tnew=0, a3=31) in E, D rs=31 with tuse=0: stall=0 and fwd_rs_d=3.
